// File: rtl/jtframe_nvram_ioctl_ctrl_if.sv
// ioctl channel plus NVRAM port-1B signals shared by the controller and its environment.
// "slave" is the controller view; "master" is the framework/RAM view.
interface jtframe_nvram_ioctl_ctrl_if #(
    parameter int unsigned AW  = 10,
    parameter int unsigned IOW = 25
);
    logic           dwn_en;
    logic           up_en;
    logic [IOW-1:0] ioctl_addr;
    logic [7:0]     ioctl_dout;
    logic           ioctl_wr;
    logic           ioctl_rd;
    logic [7:0]     ioctl_din;
    logic           din_ok;
    logic [AW:0]    nv_addr;
    logic [7:0]     nv_din;
    logic           nv_we;
    logic           nv_sel;
    logic [7:0]     nv_q;

    modport master (
        output dwn_en, up_en, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_rd, nv_q,
        input  ioctl_din, din_ok, nv_addr, nv_din, nv_we, nv_sel
    );

    modport slave (
        input  dwn_en, up_en, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_rd, nv_q,
        output ioctl_din, din_ok, nv_addr, nv_din, nv_we, nv_sel
    );
endinterface

// File: rtl/jtframe_nvram_ioctl_ctrl.sv
// Owns the byte-wide RW port of the dual-port NVRAM: loads it from ioctl downloads, dumps it
// on ioctl uploads, and keeps a dirty flag for game-side writes to request autosaves.
module jtframe_nvram_ioctl_ctrl #(
    parameter int unsigned AW   = 10,
    parameter int unsigned IOW  = 25,
    parameter logic [7:0]  FILL = 8'hFF
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    jtframe_nvram_ioctl_ctrl_if.slave   bus,
    input  logic                        i_game_we,
    output logic                        o_dirty,
    output logic                        o_busy
);

    localparam logic [IOW-1:0] ONE   = {{(IOW-1){1'b0}}, 1'b1};
    localparam logic [IOW-1:0] BYTES = ONE << (AW + 1);
    localparam logic [IOW-1:0] LAST  = BYTES - ONE;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRdIdle,
        StRdAddr,
        StRdData
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [AW:0] r_nv_addr;
    logic [7:0]  r_nv_din;
    logic        r_nv_we;
    logic [7:0]  r_ioctl_din;
    logic        r_din_ok;
    logic        r_rd_oor;
    logic        r_saw_last;
    logic        r_dirty;

    logic        w_in_range;
    logic        w_wr_ok;
    logic        w_rd_go;
    logic        w_load_done;
    logic        w_dump_done;
    logic        w_dirty_nxt;

    // Full-width compare so high ioctl address bits never alias into the RAM.
    assign w_in_range = bus.ioctl_addr < BYTES;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_ok     = 1'b0;
        w_rd_go     = 1'b0;
        w_load_done = 1'b0;
        w_dump_done = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.dwn_en) begin
                    w_state_nxt = StLoad;
                end else if (bus.up_en) begin
                    w_state_nxt = StRdIdle;
                end
            end
            StLoad: begin
                w_wr_ok = bus.ioctl_wr && w_in_range;
                // Hold select for one more cycle so a last-moment write gets its nv_we.
                if (!bus.dwn_en && !w_wr_ok) begin
                    w_state_nxt = StIdle;
                    w_load_done = 1'b1;
                end
            end
            StRdIdle: begin
                if (!bus.up_en) begin
                    w_state_nxt = StIdle;
                    w_dump_done = 1'b1;
                end else if (bus.ioctl_rd) begin
                    w_state_nxt = StRdAddr;
                    w_rd_go     = 1'b1;
                end
            end
            StRdAddr: begin
                w_state_nxt = StRdData;
            end
            StRdData: begin
                w_state_nxt = StRdIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_load_done || (w_dump_done && r_saw_last)) begin
            w_dirty_nxt = 1'b0;
        end
        if (i_game_we && (r_state != StLoad)) begin
            w_dirty_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_nv_addr   <= '0;
            r_nv_din    <= '0;
            r_nv_we     <= 1'b0;
            r_ioctl_din <= '0;
            r_din_ok    <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_saw_last  <= 1'b0;
            r_dirty     <= 1'b0;
        end else begin
            r_nv_we  <= w_wr_ok;
            r_din_ok <= (r_state == StRdData);
            r_dirty  <= w_dirty_nxt;

            if (w_wr_ok) begin
                r_nv_addr <= bus.ioctl_addr[AW:0];
                r_nv_din  <= bus.ioctl_dout;
            end else if (w_rd_go && w_in_range) begin
                r_nv_addr <= bus.ioctl_addr[AW:0];
            end

            if (w_rd_go) begin
                r_rd_oor <= !w_in_range;
            end

            if (r_state == StRdData) begin
                r_ioctl_din <= r_rd_oor ? FILL : bus.nv_q;
            end

            // Remembers whether this dump session reached the final byte.
            if (r_state == StIdle) begin
                r_saw_last <= 1'b0;
            end else if (w_rd_go && (bus.ioctl_addr == LAST)) begin
                r_saw_last <= 1'b1;
            end
        end
    end

    assign bus.nv_addr   = r_nv_addr;
    assign bus.nv_din    = r_nv_din;
    assign bus.nv_we     = r_nv_we;
    assign bus.nv_sel    = (r_state != StIdle);
    assign bus.ioctl_din = r_ioctl_din;
    assign bus.din_ok    = r_din_ok;
    assign o_busy        = (r_state != StIdle);
    assign o_dirty       = r_dirty;

    a_we_needs_sel : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.nv_we |-> bus.nv_sel);

    a_din_ok_pulse : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.din_ok |=> !bus.din_ok);

endmodule

// File: tb/tb_jtframe_nvram_ioctl_ctrl.sv
// Directed bench for jtframe_nvram_ioctl_ctrl with a behavioural 16-bit dual-port NVRAM.
module tb_jtframe_nvram_ioctl_ctrl;

    localparam int unsigned AW  = 10;
    localparam int unsigned IOW = 25;
    localparam int          NB  = 1 << (AW + 1);

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic game_we = 1'b0;
    logic dirty;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem     [0:(1<<AW)-1] = '{default: 16'h0000};
    logic [7:0]  exp_mem [0:NB-1]      = '{default: 8'h00};

    always #5 clk = ~clk;

    jtframe_nvram_ioctl_ctrl_if #(.AW(AW), .IOW(IOW)) u_if ();

    jtframe_nvram_ioctl_ctrl #(
        .AW   (AW),
        .IOW  (IOW),
        .FILL (8'hFF)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (u_if),
        .i_game_we (game_we),
        .o_dirty   (dirty),
        .o_busy    (busy)
    );

    // NVRAM port 1B: byte-wide, one-cycle read latency, bit 0 picks the high byte.
    always @(posedge clk) begin
        if (u_if.nv_sel) begin
            if (u_if.nv_we) begin
                if (u_if.nv_addr[0]) mem[u_if.nv_addr[AW:1]][15:8] <= u_if.nv_din;
                else                 mem[u_if.nv_addr[AW:1]][7:0]  <= u_if.nv_din;
            end
            u_if.nv_q <= u_if.nv_addr[0] ? mem[u_if.nv_addr[AW:1]][15:8]
                                         : mem[u_if.nv_addr[AW:1]][7:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic count_din_ok(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (u_if.din_ok) cnt++;
        end
    endtask

    task automatic rd_chk(input string tag, input logic [IOW-1:0] a, input logic [7:0] exp);
        int lat;
        bit got;
        u_if.ioctl_addr = a;
        u_if.ioctl_rd   = 1'b1;
        tick();
        u_if.ioctl_rd = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 8) begin
            if (u_if.din_ok) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({tag, "_lat"}, lat, 3);
        check(tag, u_if.ioctl_din, exp);
    endtask

    task automatic full_dump(input int last);
        logic [IOW-1:0] av;
        for (int a = 0; a <= last; a++) begin
            av = a[IOW-1:0];
            rd_chk("dump", av, exp_mem[a]);
        end
    endtask

    initial begin
        logic [15:0] w;
        int          cnt;

        u_if.dwn_en     = 1'b0;
        u_if.up_en      = 1'b0;
        u_if.ioctl_addr = '0;
        u_if.ioctl_dout = '0;
        u_if.ioctl_wr   = 1'b0;
        u_if.ioctl_rd   = 1'b0;

        // Power-on reset
        repeat (2) tick();
        check("rst_ioctl_din", u_if.ioctl_din, 0);
        check("rst_din_ok", u_if.din_ok, 0);
        check("rst_nv_addr", u_if.nv_addr, 0);
        check("rst_nv_din", u_if.nv_din, 0);
        check("rst_nv_we", u_if.nv_we, 0);
        check("rst_nv_sel", u_if.nv_sel, 0);
        check("rst_dirty", dirty, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // LOAD
        u_if.dwn_en = 1'b1;
        tick();
        check("load_busy", busy, 1);
        check("load_sel", u_if.nv_sel, 1);
        u_if.ioctl_addr = 25'h005; u_if.ioctl_dout = 8'hA5; u_if.ioctl_wr = 1'b1;
        tick();
        u_if.ioctl_wr = 1'b0;
        check("wr5_we", u_if.nv_we, 1);
        check("wr5_addr", u_if.nv_addr, 11'h005);
        check("wr5_din", u_if.nv_din, 8'hA5);
        tick();
        check("wr5_we_one_cycle", u_if.nv_we, 0);
        w = mem[2];
        check("game_word2_hi", w[15:8], 8'hA5);
        exp_mem[5] = 8'hA5;

        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        check("dirty_blocked_in_load", dirty, 0);

        u_if.ioctl_addr = 25'h3FF; u_if.ioctl_dout = 8'h5A; u_if.ioctl_wr = 1'b1;
        tick();
        u_if.ioctl_wr = 1'b0;
        check("wr3ff_we", u_if.nv_we, 1);
        check("wr3ff_addr", u_if.nv_addr, 11'h3FF);
        exp_mem[11'h3FF] = 8'h5A;
        tick();

        u_if.ioctl_addr = 25'h800; u_if.ioctl_dout = 8'h77; u_if.ioctl_wr = 1'b1;
        tick();
        check("oor800_no_we", u_if.nv_we, 0);
        u_if.ioctl_addr = 25'h1000001;
        tick();
        u_if.ioctl_wr = 1'b0;
        check("oor_wide_no_we", u_if.nv_we, 0);
        tick();
        w = mem[0];
        check("oor_no_alias", w, 16'h0000);

        // Write coinciding with the end of download still lands.
        u_if.ioctl_addr = 25'h010; u_if.ioctl_dout = 8'h3C; u_if.ioctl_wr = 1'b1;
        u_if.dwn_en = 1'b0;
        tick();
        u_if.ioctl_wr = 1'b0;
        check("lastwr_we", u_if.nv_we, 1);
        check("lastwr_sel", u_if.nv_sel, 1);
        tick();
        check("load_end_sel", u_if.nv_sel, 0);
        check("load_end_busy", busy, 0);
        check("load_end_we", u_if.nv_we, 0);
        w = mem[8];
        check("lastwr_landed", w[7:0], 8'h3C);
        exp_mem[11'h010] = 8'h3C;

        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        check("dirty_set_idle", dirty, 1);
        u_if.dwn_en = 1'b1;
        tick();
        u_if.dwn_en = 1'b0;
        tick();
        check("load_clears_dirty", dirty, 0);
        check("load2_busy", busy, 0);

        // dwn_en and up_en together: LOAD wins
        u_if.dwn_en = 1'b1; u_if.up_en = 1'b1;
        tick();
        check("both_busy", busy, 1);
        u_if.ioctl_addr = 25'h005; u_if.ioctl_rd = 1'b1;
        tick();
        u_if.ioctl_rd = 1'b0;
        count_din_ok(5, cnt);
        check("both_no_din_ok", cnt, 0);
        u_if.ioctl_addr = 25'h030; u_if.ioctl_dout = 8'h99; u_if.ioctl_wr = 1'b1;
        tick();
        u_if.ioctl_wr = 1'b0;
        check("both_is_load", u_if.nv_we, 1);
        exp_mem[11'h030] = 8'h99;
        u_if.dwn_en = 1'b0; u_if.up_en = 1'b0;
        tick();
        tick();
        check("both_end_busy", busy, 0);

        // DUMP latency and ignored second request
        u_if.up_en = 1'b1;
        tick();
        u_if.ioctl_addr = 25'h3FF; u_if.ioctl_rd = 1'b1;
        tick();
        check("lat_n1_no_ok", u_if.din_ok, 0);
        u_if.ioctl_addr = 25'h005;
        tick();
        u_if.ioctl_rd = 1'b0;
        check("lat_n2_no_ok", u_if.din_ok, 0);
        tick();
        check("lat_n3_ok", u_if.din_ok, 1);
        check("lat_n3_data", u_if.ioctl_din, 8'h5A);
        tick();
        check("din_ok_pulse", u_if.din_ok, 0);
        check("din_hold", u_if.ioctl_din, 8'h5A);
        count_din_ok(4, cnt);
        check("second_rd_ignored", cnt, 0);

        rd_chk("rd_5", 25'h005, 8'hA5);
        rd_chk("rd_oor_800", 25'h800, 8'hFF);
        rd_chk("rd_oor_wide", 25'h1000005, 8'hFF);
        rd_chk("rd_0", 25'h000, 8'h00);

        // up_en falls mid-read: the read still completes
        u_if.ioctl_addr = 25'h010; u_if.ioctl_rd = 1'b1;
        tick();
        u_if.ioctl_rd = 1'b0;
        u_if.up_en = 1'b0;
        check("midrd_busy", busy, 1);
        tick();
        tick();
        check("midrd_ok", u_if.din_ok, 1);
        check("midrd_data", u_if.ioctl_din, 8'h3C);
        tick();
        check("midrd_end_busy", busy, 0);

        // Dirty tracking across dumps
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        check("dirty_set", dirty, 1);
        u_if.up_en = 1'b1;
        tick();
        full_dump(NB - 1);
        check("dirty_before_end", dirty, 1);
        u_if.up_en = 1'b0;
        tick();
        check("full_dump_clears", dirty, 0);
        check("full_dump_busy", busy, 0);

        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        u_if.up_en = 1'b1;
        tick();
        full_dump(NB - 1);
        u_if.up_en = 1'b0;
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        check("dirty_set_wins", dirty, 1);

        u_if.up_en = 1'b1;
        tick();
        full_dump(11'h3FF);
        u_if.up_en = 1'b0;
        tick();
        check("partial_dump_keeps", dirty, 1);

        // Reset with a read in flight
        u_if.up_en = 1'b1;
        tick();
        u_if.ioctl_addr = 25'h005; u_if.ioctl_rd = 1'b1;
        tick();
        u_if.ioctl_rd = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rstrd_din_ok", u_if.din_ok, 0);
        check("rstrd_busy", busy, 0);
        check("rstrd_din", u_if.ioctl_din, 0);
        check("rstrd_dirty", dirty, 0);
        rst_n = 1'b1;
        u_if.up_en = 1'b0;
        count_din_ok(4, cnt);
        check("rstrd_no_din_ok", cnt, 0);

        // Reset mid-LOAD while ioctl_wr pulses
        u_if.dwn_en = 1'b1;
        tick();
        u_if.ioctl_addr = 25'h020; u_if.ioctl_dout = 8'h11; u_if.ioctl_wr = 1'b1;
        rst_n = 1'b0;
        tick();
        check("rstld_we", u_if.nv_we, 0);
        check("rstld_sel", u_if.nv_sel, 0);
        check("rstld_busy", busy, 0);
        check("rstld_addr", u_if.nv_addr, 0);
        check("rstld_din", u_if.nv_din, 0);
        u_if.ioctl_addr = 25'h021;
        tick();
        u_if.ioctl_wr = 1'b0;
        u_if.dwn_en = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rstld_after_we", u_if.nv_we, 0);
        check("rstld_after_busy", busy, 0);
        w = mem[16];
        check("rstld_no_write", w, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
